// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multicycle control FSM and the
// instruction/data memory ports. The controller is the master: it raises
// requests and qualifiers; the memories answer with ready.
interface multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;
  logic mem_read;
  logic mem_write;

  modport master (
    output imem_req,
    output dmem_req,
    output mem_read,
    output mem_write,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  mem_read,
    input  mem_write,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for the RV64 multicycle datapath (R-type, I-type ALU, ld, sd, beq).
// Sequence: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with a sticky
// TRAP state for unsupported opcodes and data-memory timeouts.
// Optional build macro PERF_CNT_EN adds cycle_cnt/instret_cnt counters.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_if.master    mem,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 alu_zero,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 alu_src,
  output logic [1:0]           alu_op,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [2:0]           state_o
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  // funct fields are decoded by the ALU control, not here; CNT_W only
  // matters when the counters are built.
  localparam int unused_cnt_w = CNT_W;
  logic unused_funct;
  assign unused_funct = ^{funct3, funct7_5};

  logic [2:0] state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;
  logic       retire_c;

  logic imem_req_c, dmem_req_c, mem_read_c, mem_write_c;
  logic ir_write_c, pc_write_c, pc_src_c, alu_src_c;
  logic [1:0] alu_op_c;
  logic reg_write_c, mem_to_reg_c;

  // Next-state and control decode; anything not set in a state stays 0.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    retire_c     = 1'b0;
    imem_req_c   = 1'b0;
    dmem_req_c   = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 1'b0;
    alu_src_c    = 1'b0;
    alu_op_c     = 2'b00;
    reg_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_c = run;
        if (run && mem.imem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OP_R || opcode == OP_I || opcode == OP_LD ||
            opcode == OP_SD || opcode == OP_BEQ) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_op_c = 2'b10;
            state_d  = S_WB;
          end
          OP_I: begin
            alu_src_c = 1'b1;
            alu_op_c  = 2'b10;
            state_d   = S_WB;
          end
          OP_LD, OP_SD: begin
            alu_src_c = 1'b1;
            state_d   = S_MEM;
          end
          OP_BEQ: begin
            alu_op_c   = 2'b01;
            pc_write_c = alu_zero;
            pc_src_c   = 1'b1;
            retire_c   = 1'b1;
            state_d    = S_FETCH;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_TRAP;
          end
        endcase
      end
      S_MEM: begin
        dmem_req_c  = 1'b1;
        mem_read_c  = (opcode == OP_LD);
        mem_write_c = (opcode == OP_SD);
        if (mem.dmem_ready) begin
          wait_d   = 8'd0;
          retire_c = (opcode == OP_SD);
          state_d  = (opcode == OP_LD) ? S_WB : S_FETCH;
        end else if (wait_q + 8'd1 == TIMEOUT) begin
          wait_d    = 8'd0;
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = (opcode == OP_LD);
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State, memory wait counter and sticky fault flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

  // Free-running cycle count (frozen in TRAP) and retired-instruction count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (retire_c)          instret_cnt_q <= instret_cnt_q + 1'b1;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire_c;
`endif

  // FETCH outputs are Mealy on run/imem_ready, so gating with rst_n keeps
  // every output quiet while reset is held.
  assign mem.imem_req  = rst_n & imem_req_c;
  assign mem.dmem_req  = rst_n & dmem_req_c;
  assign mem.mem_read  = rst_n & mem_read_c;
  assign mem.mem_write = rst_n & mem_write_c;
  assign ir_write      = rst_n & ir_write_c;
  assign pc_write      = rst_n & pc_write_c;
  assign pc_src        = rst_n & pc_src_c;
  assign alu_src       = rst_n & alu_src_c;
  assign alu_op        = rst_n ? alu_op_c : 2'b00;
  assign reg_write     = rst_n & reg_write_c;
  assign mem_to_reg    = rst_n & mem_to_reg_c;
  assign illegal       = illegal_q;
  assign bus_err       = bus_err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl. Each cycle the full
// control word is compared with a hand-derived expected vector laid out as
// {imem_req,dmem_req,mem_read,mem_write,ir_write,pc_write,pc_src,alu_src,
//  alu_op[1:0], reg_write,mem_to_reg,illegal,bus_err, state[2:0]}.
// Build with +define+PERF_CNT_EN to also exercise the performance counters.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Commonly used expected control words.
  localparam logic [16:0] E_FETCH_GO = {8'b1000_1100, 2'b00, 4'b0000, 3'd0};
  localparam logic [16:0] E_IDLE     = 17'd0;
  localparam logic [16:0] E_DECODE   = {8'b0000_0000, 2'b00, 4'b0000, 3'd1};
  localparam logic [16:0] E_EX_MEMOP = {8'b0000_0001, 2'b00, 4'b0000, 3'd2};
  localparam logic [16:0] E_MEM_LD   = {8'b0110_0000, 2'b00, 4'b0000, 3'd3};
  localparam logic [16:0] E_MEM_SD   = {8'b0101_0000, 2'b00, 4'b0000, 3'd3};
  localparam logic [16:0] E_WB_ALU   = {8'b0000_0000, 2'b00, 4'b1000, 3'd4};
  localparam logic [16:0] E_TRAP_ILL = {8'b0000_0000, 2'b00, 4'b0010, 3'd5};
  localparam logic [16:0] E_TRAP_BUS = {8'b0000_0000, 2'b00, 4'b0001, 3'd5};

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       alu_zero;
  logic       ir_write, pc_write, pc_src, alu_src, reg_write, mem_to_reg;
  logic [1:0] alu_op;
  logic       illegal, bus_err;
  logic [2:0] state_o;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int errors = 0;
  int checks = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (bus),
    .run        (run),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .alu_zero   (alu_zero),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .state_o    (state_o)
`ifdef PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  logic [16:0] obs;
  assign obs = {bus.imem_req, bus.dmem_req, bus.mem_read, bus.mem_write,
                ir_write, pc_write, pc_src, alu_src, alu_op,
                reg_write, mem_to_reg, illegal, bus_err, state_o};

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    run            = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    alu_zero       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n          = 1'b0;
    run            = 1'b1;
    bus.imem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== E_IDLE) begin
      errors++;
      $display("[TB] FAIL reset_quiet: got %b expected %b", obs, E_IDLE);
    end
    tick();
    rst_n = 1'b1;
    run   = 1'b0;
    #1;
    checks++;
    if (obs !== E_IDLE) begin
      errors++;
      $display("[TB] FAIL reset_release: got %b expected %b", obs, E_IDLE);
    end
    run            = 1'b1;
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (obs !== {8'b1000_0000, 2'b00, 4'b0000, 3'd0}) begin
        errors++;
        $display("[TB] FAIL fetch_wait cycle %0d: got %b expected %b", i, obs,
                 {8'b1000_0000, 2'b00, 4'b0000, 3'd0});
      end
      tick();
    end
  endtask

  task automatic test_addi();
    logic [16:0] e [5];
    e = '{E_FETCH_GO, E_DECODE, {8'b0000_0001, 2'b10, 4'b0000, 3'd2}, E_WB_ALU, E_IDLE};
    do_reset();
    opcode         = OP_I;
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run = (i == 0);
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("[TB] FAIL addi cycle %0d: got %b expected %b", i, obs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] e [9];
    e = '{E_FETCH_GO, E_DECODE, {8'b0000_0000, 2'b10, 4'b0000, 3'd2}, E_WB_ALU,
          E_FETCH_GO, E_DECODE, {8'b0000_0001, 2'b10, 4'b0000, 3'd2}, E_WB_ALU,
          E_IDLE};
    do_reset();
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run    = (i < 5);
      opcode = (i < 5) ? OP_R : OP_I;
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("[TB] FAIL r_then_i cycle %0d: got %b expected %b", i, obs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_ld_wait();
    logic [16:0] e [9];
    e = '{E_FETCH_GO, E_DECODE, E_EX_MEMOP, E_MEM_LD, E_MEM_LD, E_MEM_LD, E_MEM_LD,
          {8'b0000_0000, 2'b00, 4'b1100, 3'd4}, E_IDLE};
    do_reset();
    opcode         = OP_LD;
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run            = (i == 0);
      bus.dmem_ready = (i == 6);
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("[TB] FAIL ld_wait3 cycle %0d: got %b expected %b", i, obs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_sd();
    logic [16:0] e [5];
    e = '{E_FETCH_GO, E_DECODE, E_EX_MEMOP, E_MEM_SD, E_IDLE};
    do_reset();
    opcode         = OP_SD;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run = (i == 0);
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("[TB] FAIL sd cycle %0d: got %b expected %b", i, obs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_beq();
    logic [16:0] e [7];
    e = '{E_FETCH_GO, E_DECODE, {8'b0000_0110, 2'b01, 4'b0000, 3'd2},
          E_FETCH_GO, E_DECODE, {8'b0000_0010, 2'b01, 4'b0000, 3'd2}, E_IDLE};
    do_reset();
    opcode         = OP_BEQ;
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run      = (i == 0) || (i == 3);
      alu_zero = (i < 3);
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("[TB] FAIL beq cycle %0d: got %b expected %b", i, obs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [16:0] exp_v;
    do_reset();
    opcode         = 7'b1111111;
    bus.imem_ready = 1'b1;
    run            = 1'b1;
    for (int i = 0; i < 23; i++) begin
      bus.dmem_ready = i[0];
      alu_zero       = i[1];
      exp_v = (i == 0) ? E_FETCH_GO : (i == 1) ? E_DECODE : E_TRAP_ILL;
      #1;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL illegal cycle %0d: got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== E_IDLE) begin
      errors++;
      $display("[TB] FAIL illegal_clear: got %b expected %b", obs, E_IDLE);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    logic [16:0] exp_v;
    // No ready at all: 16 MEM cycles then TRAP with bus_err.
    do_reset();
    opcode         = OP_SD;
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      run   = (i == 0);
      exp_v = (i == 0) ? E_FETCH_GO : (i == 1) ? E_DECODE : (i == 2) ? E_EX_MEMOP :
              (i <= 18) ? E_MEM_SD : E_TRAP_BUS;
      #1;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL sd_timeout cycle %0d: got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
    // Ready on the very edge the counter reaches the limit: ready wins.
    do_reset();
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      run            = (i == 0);
      bus.dmem_ready = (i == 18);
      exp_v = (i == 0) ? E_FETCH_GO : (i == 1) ? E_DECODE : (i == 2) ? E_EX_MEMOP :
              (i <= 18) ? E_MEM_SD : E_IDLE;
      #1;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL ready_wins cycle %0d: got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
    // Retry after a timeout, then abort with reset in the middle of MEM.
    do_reset();
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run   = (i == 0);
      exp_v = (i == 0) ? E_FETCH_GO : (i == 1) ? E_DECODE : (i == 2) ? E_EX_MEMOP : E_MEM_SD;
      #1;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL retry cycle %0d: got %b expected %b", i, obs, exp_v);
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== E_IDLE) begin
      errors++;
      $display("[TB] FAIL mid_mem_reset: got %b expected %b", obs, E_IDLE);
    end
    tick();
    rst_n = 1'b1;
  endtask

`ifdef PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    alu_zero       = 1'b0;
    checks++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL perf_reset: got cycle=%0d instret=%0d expected 0/0",
               cycle_cnt, instret_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      run    = 1'b1;
      opcode = (i < 4) ? OP_I : (i < 9) ? OP_LD : (i < 13) ? OP_SD : OP_BEQ;
      tick();
    end
    run = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd0 || cycle_cnt !== 32'd16 || instret_cnt !== 32'd4) begin
      errors++;
      $display("[TB] FAIL perf_mix: got state=%0d cycle=%0d instret=%0d expected 0/16/4",
               state_o, cycle_cnt, instret_cnt);
    end
  endtask
`endif

  initial begin
    rst_n          = 1'b0;
    run            = 1'b0;
    opcode         = 7'd0;
    funct3         = 3'b000;
    funct7_5       = 1'b0;
    alu_zero       = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_ld_wait();
    test_sd();
    test_beq();
    test_illegal();
    test_timeout();
`ifdef PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
